// File: rtl/arbitro_registro.sv
// Round-robin arbiter sharing one N-bit result register among M requesters.
// Each grant lasts one cycle. On the following edge the granted data is written
// (commit) if its request is still up. Otherwise the write is dropped (abort).
module arbitro_registro #(
  parameter int unsigned N = 3,
  parameter int unsigned M = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [M-1:0]           req,
  input  logic [M*N-1:0]         datos,
  output logic [M-1:0]           gnt,
  output logic                   hecho,
  output logic                   ocupado,
  output logic [N-1:0]           salida,
  output logic [$clog2(M)-1:0]   dueno
);

  localparam int unsigned IW = $clog2(M);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} estado_t;

  estado_t        state_q, state_d;
  logic [M-1:0]   gnt_q, gnt_d;
  logic           hecho_q, hecho_d;
  logic           ocupado_q, ocupado_d;
  logic [N-1:0]   salida_q, salida_d;
  logic [IW-1:0]  dueno_q, dueno_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [IW-1:0]  g_q, g_d;

  logic [N-1:0]   dat_arr [M];
  logic [IW-1:0]  sel;
  logic           found;
  logic [IW-1:0]  cand;

  // Unpack the flattened data bus into one entry per requester
  for (genvar i = 0; i < M; i++) begin : g_unpack
    assign dat_arr[i] = datos[i*N +: N];
  end

  // Cyclic search starting just after the last committed requester
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= M; k++) begin
      cand = IW'((32'(ptr_q) + k) % M);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    gnt_d     = '0;
    hecho_d   = 1'b0;
    ocupado_d = 1'b0;
    salida_d  = salida_q;
    dueno_d   = dueno_q;
    ptr_d     = ptr_q;
    g_d       = g_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d   = GRANT;
          gnt_d     = M'(1) << sel;
          ocupado_d = 1'b1;
          g_d       = sel;
        end
      end
      GRANT: begin
        state_d = IDLE;
        if (req[g_q]) begin
          salida_d = dat_arr[g_q];
          hecho_d  = 1'b1;
          dueno_d  = g_q;
          ptr_d    = g_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; after reset requester 0 has top priority
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      hecho_q   <= 1'b0;
      ocupado_q <= 1'b0;
      salida_q  <= '0;
      dueno_q   <= '0;
      ptr_q     <= IW'(M - 1);
      g_q       <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      hecho_q   <= hecho_d;
      ocupado_q <= ocupado_d;
      salida_q  <= salida_d;
      dueno_q   <= dueno_d;
      ptr_q     <= ptr_d;
      g_q       <= g_d;
    end
  end

  assign gnt     = gnt_q;
  assign hecho   = hecho_q;
  assign ocupado = ocupado_q;
  assign salida  = salida_q;
  assign dueno   = dueno_q;

endmodule
